// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio constants and the 32-bit to 16-bit sample
//                saturation helper used by the codec DAC serializer.
//  Contents    : SAMPLE_W   - width of a stored/serialized sample
//                FRAME_BITS - bit clocks per stereo frame (16 left + 16 right)
//                sat_sample - clamp a signed 32-bit integer into 16 bits
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;

    // Clamp to the signed 16-bit range; in-range values pass through as their
    // low 16 bits, which is exact two's-complement for that range.
    function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [31:0] x);
        logic signed [SAMPLE_W-1:0] res;
        if (x > 32'sd32767) begin
            res = 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            res = 16'sh8000;
        end else begin
            res = x[SAMPLE_W-1:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Synchronous sample buffer with an occupancy count. A push and
//                a pop may happen on the same clock; a push into a full buffer
//                is accepted only when a pop frees a slot on that same clock.
//                Reads are combinational from the head entry (no bypass, so a
//                pop of an empty buffer never returns the word being pushed).
//  Ports       : i_clk    - system clock, rising edge
//                i_rst_n  - asynchronous active-low reset (empties the buffer)
//                i_push   - write request, i_data is stored if space allows
//                i_data   - word to store
//                i_pop    - read request, ignored when empty
//                o_data   - head entry (valid when o_count != 0)
//                o_count  - number of stored entries, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int                c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_full  = (c_ptr_w+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr_q;
    logic [c_ptr_w-1:0] w_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q;
    logic [c_ptr_w-1:0] w_rd_ptr_d;
    logic [c_ptr_w:0]   r_count_q;
    logic [c_ptr_w:0]   w_count_d;
    logic               w_pop_ok;
    logic               w_push_ok;

    always_comb begin
        w_pop_ok   = i_pop && (r_count_q != '0);
        // A same-cycle pop makes room, so a full buffer can still take a push.
        w_push_ok  = i_push && ((r_count_q != c_full) || w_pop_ok);
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop_ok) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr_q];
    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/int_sample_to_dac.sv
`default_nettype none
// ============================================================================
//  Module      : int_sample_to_dac
//  Description : Takes signed 32-bit samples from the float-to-int stage,
//                saturates them to 16 bits, buffers them and serializes one
//                sample per stereo frame (same value on left and right,
//                left-justified, MSB first) to an audio codec DAC.
//  Ports       : clock       - system clock, rising edge
//                reset_n     - asynchronous active-low reset
//                dataa       - signed 32-bit sample
//                done        - one-cycle strobe qualifying dataa
//                aud_bclk    - codec bit clock (BCLK_DIV clocks per half-period)
//                aud_daclrck - frame clock, 1 = left channel
//                aud_dacdat  - serial data, changes on aud_bclk falling edges
//                fifo_full   - buffer holds FIFO_DEPTH samples
//                overflow    - one-cycle pulse, incoming sample dropped
//                underrun    - one-cycle pulse, frame started with no sample
//  Revision    : 1.0 - initial release
// ============================================================================
module int_sample_to_dac
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dataa,
    input  logic        done,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic        fifo_full,
    output logic        overflow,
    output logic        underrun
);

    localparam int                  c_div_w    = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(BCLK_DIV - 1);
    localparam int                  c_bit_w    = $clog2(FRAME_BITS);
    localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(FRAME_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_half = c_bit_w'(FRAME_BITS / 2);
    localparam int                  c_cnt_w    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0]  c_fifo_max = c_cnt_w'(FIFO_DEPTH);

    logic [c_div_w-1:0]  r_div_q;
    logic [c_div_w-1:0]  w_div_d;
    logic                r_bclk_q;
    logic                w_bclk_d;
    logic [c_bit_w-1:0]  r_bit_q;
    logic [c_bit_w-1:0]  w_bit_d;
    logic                r_started_q;
    logic                w_started_d;
    logic                r_lrck_q;
    logic                w_lrck_d;
    logic [SAMPLE_W-1:0] r_held_q;
    logic [SAMPLE_W-1:0] w_held_d;
    logic [SAMPLE_W-1:0] r_shreg_q;
    logic [SAMPLE_W-1:0] w_shreg_d;

    logic                w_div_wrap;
    logic                w_bclk_fall;
    logic                w_frame_start;
    logic                w_fifo_empty;
    logic                w_pop;
    logic [SAMPLE_W-1:0] w_sat;
    logic [SAMPLE_W-1:0] w_fifo_data;
    logic [SAMPLE_W-1:0] w_load_sample;
    logic [c_cnt_w-1:0]  w_fifo_count;

    assign w_sat = sat_sample($signed(dataa));

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_push  (done),
        .i_data  (w_sat),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );

    assign fifo_full    = (w_fifo_count == c_fifo_max);
    assign w_fifo_empty = (w_fifo_count == '0);

    // Frame timing decode. The bit counter sits at 0 out of reset, so the very
    // first bclk falling edge is a frame start without advancing the counter;
    // after that a frame starts whenever the counter wraps from its last bit.
    assign w_div_wrap    = (r_div_q == c_div_last);
    assign w_bclk_fall   = w_div_wrap && r_bclk_q;
    assign w_frame_start = w_bclk_fall && (!r_started_q || (r_bit_q == c_bit_last));
    assign w_pop         = w_frame_start && !w_fifo_empty;

    assign underrun = w_frame_start && w_fifo_empty;
    assign overflow = done && fifo_full && !w_pop;

    // A fresh pop feeds the shift register directly on the frame-start edge,
    // the held copy then serves the right channel and any underrun frames.
    assign w_load_sample = w_pop ? w_fifo_data : r_held_q;

    always_comb begin
        w_div_d     = w_div_wrap ? '0 : (r_div_q + 1'b1);
        w_bclk_d    = w_div_wrap ? ~r_bclk_q : r_bclk_q;
        w_bit_d     = r_bit_q;
        w_started_d = r_started_q;
        w_lrck_d    = r_lrck_q;
        w_held_d    = r_held_q;
        w_shreg_d   = r_shreg_q;
        if (w_bclk_fall) begin
            w_started_d = 1'b1;
            if (!r_started_q || (r_bit_q == c_bit_last)) begin
                w_bit_d = '0;
            end else begin
                w_bit_d = r_bit_q + 1'b1;
            end
            w_lrck_d = (w_bit_d < c_bit_half);
            if (w_pop) begin
                w_held_d = w_fifo_data;
            end
            if ((w_bit_d == '0) || (w_bit_d == c_bit_half)) begin
                w_shreg_d = w_load_sample;
            end else begin
                w_shreg_d = {r_shreg_q[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div_q     <= '0;
            r_bclk_q    <= 1'b0;
            r_bit_q     <= '0;
            r_started_q <= 1'b0;
            r_lrck_q    <= 1'b0;
            r_held_q    <= '0;
            r_shreg_q   <= '0;
        end else begin
            r_div_q     <= w_div_d;
            r_bclk_q    <= w_bclk_d;
            r_bit_q     <= w_bit_d;
            r_started_q <= w_started_d;
            r_lrck_q    <= w_lrck_d;
            r_held_q    <= w_held_d;
            r_shreg_q   <= w_shreg_d;
        end
    end

    assign aud_bclk    = r_bclk_q;
    assign aud_daclrck = r_lrck_q;
    assign aud_dacdat  = r_shreg_q[SAMPLE_W-1];

endmodule
`default_nettype wire

// File: tb/tb_int_sample_to_dac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_sample_to_dac
//  Description : Self-checking bench. Two DUT instances (BCLK_DIV 2 and 8,
//                FIFO_DEPTH 8) share stimulus. A frame-arithmetic reference
//                model predicts every output on every cycle; directed phases
//                pin serialized words and pulse timing with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_sample_to_dac;

    localparam int c_n     = 2;
    localparam int c_depth = 8;
    localparam int c_div_a = 2;
    localparam int c_div_b = 8;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] dataa   = '0;
    logic        done    = 1'b0;

    logic [c_n-1:0] bclk_w;
    logic [c_n-1:0] lrck_w;
    logic [c_n-1:0] dat_w;
    logic [c_n-1:0] full_w;
    logic [c_n-1:0] ovf_w;
    logic [c_n-1:0] und_w;

    int checks = 0;
    int errors = 0;

    // reference model state: edges since reset release, queue, held sample
    int unsigned m_n    [c_n];
    logic [15:0] m_held [c_n];
    logic [15:0] m_q    [c_n][$];

    // deserializer of the DUT serial stream: {lrck, 16-bit word}
    logic        cap_prev [c_n];
    logic        cap_lr   [c_n];
    logic [15:0] cap_sh   [c_n];
    int          cap_cnt  [c_n];
    logic [16:0] cap_q    [c_n][$];

    always #5 clock = ~clock;

    int_sample_to_dac #(.FIFO_DEPTH(c_depth), .BCLK_DIV(c_div_a)) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .dataa       (dataa),
        .done        (done),
        .aud_bclk    (bclk_w[0]),
        .aud_daclrck (lrck_w[0]),
        .aud_dacdat  (dat_w[0]),
        .fifo_full   (full_w[0]),
        .overflow    (ovf_w[0]),
        .underrun    (und_w[0])
    );

    int_sample_to_dac #(.FIFO_DEPTH(c_depth), .BCLK_DIV(c_div_b)) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .dataa       (dataa),
        .done        (done),
        .aud_bclk    (bclk_w[1]),
        .aud_daclrck (lrck_w[1]),
        .aud_dacdat  (dat_w[1]),
        .fifo_full   (full_w[1]),
        .overflow    (ovf_w[1]),
        .underrun    (und_w[1])
    );

    function automatic logic [15:0] sat_model(input logic [31:0] v);
        int s;
        s = $signed(v);
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic check_word(input int i, input int idx, input logic [16:0] exp);
        checks++;
        if (cap_q[i].size() <= idx) begin
            errors++;
            $display("FAIL word%0d dut%0d missing (have %0d) expected %h", idx, i, cap_q[i].size(), exp);
        end else if (cap_q[i][idx] !== exp) begin
            errors++;
            $display("FAIL word%0d dut%0d got %h expected %h", idx, i, cap_q[i][idx], exp);
        end
    endtask

    // Model + compare, mid-cycle. Inputs are stable here until the next
    // rising edge, so the model also advances across that edge now.
    always @(negedge clock) begin
        for (int i = 0; i < c_n; i++) begin
            int   d;
            int   n;
            int   p;
            bit   fs;
            bit   pop;
            bit   ovf;
            bit   und;
            bit   e_bclk;
            bit   e_lr;
            bit   e_dat;
            bit   e_full;
            d = (i == 0) ? c_div_a : c_div_b;
            if (!reset_n) begin
                m_n[i]    = 0;
                m_held[i] = '0;
                m_q[i].delete();
                cap_prev[i] = 1'b0;
                cap_lr[i]   = 1'b0;
                cap_sh[i]   = '0;
                cap_cnt[i]  = 0;
                cap_q[i].delete();
                check("rst_bclk", i, bclk_w[i], 0);
                check("rst_lrck", i, lrck_w[i], 0);
                check("rst_dat",  i, dat_w[i],  0);
                check("rst_full", i, full_w[i], 0);
                check("rst_ovf",  i, ovf_w[i],  0);
                check("rst_und",  i, und_w[i],  0);
            end else begin
                if (bclk_w[i] && !cap_prev[i]) begin
                    if (lrck_w[i] != cap_lr[i]) begin
                        cap_cnt[i] = 0;
                        cap_lr[i]  = lrck_w[i];
                    end
                    cap_sh[i]  = {cap_sh[i][14:0], dat_w[i]};
                    cap_cnt[i] = cap_cnt[i] + 1;
                    if (cap_cnt[i] == 16) begin
                        cap_q[i].push_back({lrck_w[i], cap_sh[i]});
                        cap_cnt[i] = 0;
                    end
                end
                cap_prev[i] = bclk_w[i];

                n      = int'(m_n[i]);
                e_bclk = ((n / d) % 2) == 1;
                if (n < 2 * d) begin
                    e_lr  = 1'b0;
                    e_dat = 1'b0;
                end else begin
                    p     = (n / (2 * d) - 1) % 32;
                    e_lr  = (p < 16);
                    e_dat = m_held[i][15 - (p % 16)];
                end
                e_full = (m_q[i].size() == c_depth);
                fs  = (((n + 1) % (2 * d)) == 0) && ((((n + 1) / (2 * d) - 1) % 32) == 0);
                pop = fs && (m_q[i].size() > 0);
                und = fs && (m_q[i].size() == 0);
                ovf = done && e_full && !pop;

                check("bclk",     i, bclk_w[i], e_bclk);
                check("lrck",     i, lrck_w[i], e_lr);
                check("dacdat",   i, dat_w[i],  e_dat);
                check("fifofull", i, full_w[i], e_full);
                check("overflow", i, ovf_w[i],  ovf);
                check("underrun", i, und_w[i],  und);

                if (pop) m_held[i] = m_q[i].pop_front();
                if (done && !ovf) m_q[i].push_back(sat_model(dataa));
                m_n[i] = m_n[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with reset released; the
    // next rising edge is edge 1 after release.
    task automatic do_reset();
        reset_n = 1'b0;
        done    = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic strobe(input logic [31:0] v);
        done  = 1'b1;
        dataa = v;
        tick();
        done  = 1'b0;
    endtask

    task automatic wait_words(input int i, input int cnt, input int budget);
        for (int t = 0; t < budget && cap_q[i].size() < cnt; t++) tick();
    endtask

    logic [15:0] p1_words [4] = '{16'h1234, 16'h7FFF, 16'h8000, 16'hFFFB};
    logic [31:0] bnd      [6] = '{32'd32767, 32'd32768, 32'hFFFF_8000, 32'hFFFF_7FFF,
                                  32'h7FFF_FFFF, 32'h8000_0000};

    initial begin
        // framing and saturation on the BCLK_DIV=2 instance
        do_reset();
        tick();
        strobe(32'h0000_1234);
        strobe(32'd100000);
        strobe(-32'sd100000);
        strobe(-32'sd5);
        wait_words(0, 8, 700);
        for (int j = 0; j < 4; j++) begin
            check_word(0, 2 * j,     {1'b1, p1_words[j]});
            check_word(0, 2 * j + 1, {1'b0, p1_words[j]});
        end

        // overflow on the BCLK_DIV=8 instance (first frame at edge 16)
        do_reset();
        for (int j = 1; j <= 8; j++) begin
            strobe(32'(j * 17));
            if (j == 7) begin
                @(negedge clock);
                check("B_full_after7", 1, full_w[1], 0);
            end
        end
        done  = 1'b1;
        dataa = 32'(9 * 17);
        @(negedge clock);
        check("B_full_after8", 1, full_w[1], 1);
        check("B_ovf_on9",     1, ovf_w[1],  1);
        tick();
        done = 1'b0;
        @(negedge clock);
        check("B_ovf_single", 1, ovf_w[1], 0);
        tick();
        wait_words(1, 16, 4400);
        for (int j = 1; j <= 8; j++) begin
            check_word(1, 2 * j - 2, {1'b1, 16'(j * 17)});
            check_word(1, 2 * j - 1, {1'b0, 16'(j * 17)});
        end

        // underrun: one sample, then nothing
        do_reset();
        tick();
        strobe(32'h0000_0100);
        tick();
        @(negedge clock);
        check("A_und_frame1", 0, und_w[0], 0);
        repeat (128) tick();
        @(negedge clock);
        check("A_und_frame2", 0, und_w[0], 1);
        wait_words(0, 4, 300);
        for (int j = 0; j < 4; j++) check_word(0, j, {1'(j % 2 == 0), 16'h0100});

        // write coinciding with the first frame start on an empty buffer
        do_reset();
        repeat (3) tick();
        done  = 1'b1;
        dataa = 32'h0000_0ABC;
        @(negedge clock);
        check("A_und_coincide", 0, und_w[0], 1);
        tick();
        done = 1'b0;
        wait_words(0, 4, 300);
        check_word(0, 0, {1'b1, 16'h0000});
        check_word(0, 1, {1'b0, 16'h0000});
        check_word(0, 2, {1'b1, 16'h0ABC});
        check_word(0, 3, {1'b0, 16'h0ABC});

        // reset at bit counter 20 of the first frame (edge 86, bclk high)
        do_reset();
        strobe(32'hFFFF_FFFF);
        strobe(32'hFFFF_FFFF);
        strobe(32'hFFFF_FFFF);
        repeat (83) tick();
        check("A_pre_bclk", 0, bclk_w[0], 1);
        check("A_pre_lrck", 0, lrck_w[0], 0);
        check("A_pre_dat",  0, dat_w[0],  1);
        reset_n = 1'b0;
        #1;
        check("A_mid_bclk", 0, bclk_w[0], 0);
        check("A_mid_dat",  0, dat_w[0],  0);
        check("A_mid_und",  0, und_w[0],  0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        check("A_post_und", 0, und_w[0], 1);
        wait_words(0, 2, 300);
        check_word(0, 0, {1'b1, 16'h0000});
        check_word(0, 1, {1'b0, 16'h0000});

        // randomized traffic, checked every cycle by the model
        do_reset();
        for (int s = 0; s < 6; s++) begin
            int rate;
            if (s == 3) do_reset();
            rate = (s % 2 == 0) ? 12 : 60;
            for (int t = 0; t < 500; t++) begin
                done = ($urandom_range(0, rate - 1) == 0);
                case ($urandom_range(0, 3))
                    0:       dataa = $urandom;
                    1:       dataa = 32'($urandom_range(0, 65535)) - 32'd32768;
                    2:       dataa = bnd[$urandom_range(0, 5)];
                    default: dataa = 32'($urandom_range(0, 200000)) - 32'd100000;
                endcase
                tick();
            end
            done = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_sample_to_dac.md
INT_SAMPLE_TO_DAC -- requirements
Module: int_sample_to_dac

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning sample buffer entries (power of two, >=2).
REQ-002 SHALL have parameter BCLK_DIV, default 16, meaning clock cycles per aud_bclk half-period.
REQ-003 SHALL have port clock  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port dataa  in  32  signed integer sample from the float-to-int stage.
REQ-006 SHALL have port done  in  1  one-cycle strobe qualifying dataa.
REQ-007 SHALL have port aud_bclk  out  1  codec bit clock.
REQ-008 SHALL have port aud_daclrck  out  1  codec DAC frame clock; 1 = left channel.
REQ-009 SHALL have port aud_dacdat  out  1  codec serial data, MSB first.
REQ-010 SHALL have port fifo_full  out  1  buffer holds FIFO_DEPTH samples.
REQ-011 SHALL have port overflow  out  1  one-cycle pulse: sample dropped.
REQ-012 SHALL have port underrun  out  1  one-cycle pulse: frame started with empty buffer.

Function
REQ-013 SHALL saturate dataa to 16-bit signed before storing: >32767 -> 32767; <-32768 -> -32768; otherwise dataa[15:0].
REQ-014 SHALL write the saturated sample into the FIFO on any clock where done=1 and the FIFO is not full after the same-cycle pop.
REQ-015 SHALL drop the sample and pulse overflow in that cycle when done=1 and the FIFO is full with no same-cycle pop.
REQ-016 SHALL run a divider 0..BCLK_DIV-1; aud_bclk toggles on each divider wrap; first rising edge at clock BCLK_DIV after reset release.
REQ-017 SHALL run a bit counter 0..31, advanced on every aud_bclk falling edge (registered 1->0 toggle), wrapping 31->0.
REQ-018 SHALL drive aud_daclrck=1 while bit counter is 0..15 and 0 while 16..31, updated with the bit counter.
REQ-019 SHALL treat the falling edge where bit counter becomes 0 as frame start; the first frame starts at clock 2*BCLK_DIV after reset release.
REQ-020 SHALL at frame start pop one FIFO entry into a held-sample register if non-empty; if empty, keep the held sample unchanged and pulse underrun.
REQ-021 SHALL load a 16-bit shift register with the held sample at bit counter 0 and again at 16 (same sample to both channels, left-justified).
REQ-022 SHALL present shift register MSB on aud_dacdat, shifting once per aud_bclk falling edge, so bit 15 appears in the first bclk period of each channel.
REQ-023 SHALL accept a write and a pop in the same cycle; pop of an empty FIFO in the same cycle as a write is an underrun and the written sample remains stored (no bypass).
REQ-024 SHALL assert fifo_full combinationally from the occupancy count (== FIFO_DEPTH).

Reset
REQ-025 SHALL on reset_n=0, immediately and regardless of frame position: aud_bclk=0, aud_daclrck=0, aud_dacdat=0, overflow=0, underrun=0, FIFO empty, held sample=0, divider and bit counter=0.
REQ-026 SHALL restart framing per REQ-016/019 after reset release; a reset mid-frame discards the partial frame and all buffered samples.

Structure
REQ-027 SHALL take SAMPLE_W=16, FRAME_BITS=32 and the saturation function from shared package audio_pkg.
REQ-028 SHALL implement the buffer as sub-module sample_fifo (synchronous, occupancy count, simultaneous push/pop).

Verification
REQ-029 SHALL test saturation: dataa=100000 -> 0x7FFF serialized; dataa=-100000 -> 0x8000; dataa=-5 -> 0xFFFB.
REQ-030 SHALL test framing: BCLK_DIV=2, write 0x1234 before first frame -> aud_daclrck high for 16 bclks carrying 0x1234 MSB first, low for 16 carrying 0x1234.
REQ-031 SHALL test overflow: FIFO_DEPTH=8, 9 done strobes before first frame -> fifo_full after 8th, overflow pulse on 9th, first 8 samples emitted in order.
REQ-032 SHALL test underrun: one sample 0x0100 then none -> frame 1 emits 0x0100, frame 2 pulses underrun and re-emits 0x0100.
REQ-033 SHALL test write/pop coincidence: done strobed at frame-start clock with FIFO empty -> underrun pulse, sample emitted next frame.
REQ-034 SHALL test reset mid-frame: reset_n low at bit counter 20 -> all outputs 0 same cycle, FIFO empty, first frame 2*BCLK_DIV clocks after release.
